// File: rtl/bus_dev_tx_fifo_pkg.sv
// Shared definitions for the per-device bus port: word-width derivation,
// counter-width helper and the default bus word type.
package bus_dev_tx_fifo_pkg;

   localparam int PCKG_SZ_DEF = 16;

   // Payload width carried on D_pop/D_push; 8 bits of the package are framing.
   function automatic int word_width(input int pckg_sz);
      return pckg_sz - 8;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef logic [PCKG_SZ_DEF-9:0] bus_word_t;

endpackage

// File: rtl/bus_dev_tx_fifo_mem.sv
// DEPTH x W register array for the transmit FIFO: one synchronous write port,
// one asynchronous read port. Contents are not reset; validity comes from the count.
module bus_dev_tx_fifo_mem #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bus_dev_tx_fifo.sv
// Device-side transmit FIFO: buffers host words and presents the head word to
// the bus as pndng/D_pop with first-word fall-through, one word per accepted pop.
module bus_dev_tx_fifo
   import bus_dev_tx_fifo_pkg::*;
#(
   parameter int  PCKG_SZ = 16,
   parameter int  DEPTH   = 8,
   parameter int  AF_LVL  = 6,
   localparam int W       = word_width(PCKG_SZ),
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   output logic          full,
   output logic          almost_full,
   output logic [CW-1:0] count,
   output logic          pndng,
   input  logic          pop,
   output logic [W-1:0]  D_pop,
   output logic          ovf,
   output logic          udf,
   input  logic          clr_err
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          ovf_q;
   logic          udf_q;
   logic [W-1:0]  rd_data;

   logic pop_acc;
   logic wr_acc;
   logic ovf_set;
   logic udf_set;

   // A pop frees a slot in the same cycle, so a full FIFO may still take a write.
   assign pop_acc = pop && pndng;
   assign wr_acc  = wr_en && (!full || pop_acc);
   assign ovf_set = wr_en && full && !pop_acc;
   assign udf_set = pop && !pndng;

   bus_dev_tx_fifo_mem #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_acc && !pop_acc) begin
            count_q <= count_q + 1'b1;
         end else if (pop_acc && !wr_acc) begin
            count_q <= count_q - 1'b1;
         end
         // A fresh error in the clearing cycle keeps its flag set.
         ovf_q <= ovf_set || (ovf_q && !clr_err);
         udf_q <= udf_set || (udf_q && !clr_err);
      end
   end

   assign count       = count_q;
   assign pndng       = (count_q != '0);
   assign full        = (count_q == DEPTH_C);
   assign almost_full = (count_q >= AF_C);
   assign D_pop       = pndng ? rd_data : '0;
   assign ovf         = ovf_q;
   assign udf         = udf_q;

endmodule
